esm_rst_seq: RTL and testbench

//   Reset sequencer fed by the clock generator's clkOut/locked outputs.

---
 rtl/esm_rst_seq.sv | 204 ++++++++++++++++++++
 tb/tb_esm_rst_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/esm_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : esm_rst_seq
// Description : Reset sequencer. After clock lock, reset is stretched, then
//               memory, bus and CPU resets are released in order. Optional
//               swReset debounce is enabled by defining ESM_RST_DEBOUNCE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module esm_rst_seq #(
    parameter int STRETCH_CYCLES  = 1024,
    parameter int STAGE_CYCLES    = 16,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       locked,
    input  logic       swReset,
    output logic       rstMem,
    output logic       rstBus,
    output logic       rstCpu,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] lossCnt
);

    localparam logic [19:0] c_STRETCH_M1 = (STRETCH_CYCLES == 0) ? 20'd0 : 20'(STRETCH_CYCLES - 1);
    localparam logic [19:0] c_STAGE_M1   = (STAGE_CYCLES == 0)   ? 20'd0 : 20'(STAGE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAITLOCK = 3'd0,
        S_STRETCH  = 3'd1,
        S_MEM      = 3'd2,
        S_BUS      = 3'd3,
        S_RUN      = 3'd4
    } state_t;

    logic [1:0]  r_lockSync;
    logic [1:0]  r_swSync;
    logic        w_lockedS;
    logic        w_swS;
    logic        w_swF;

    state_t      r_state;
    state_t      w_next;
    logic [19:0] r_cnt;
    logic [19:0] w_cntNext;
    logic        r_swHeld;
    logic        w_swHeldNext;
    logic        w_lossInc;
    logic [7:0]  r_lossCnt;
    logic        r_rstMem, r_rstBus, r_rstCpu, r_ready;
    logic        w_rstMem, w_rstBus, w_rstCpu, w_ready;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_lockSync <= 2'b00;
            r_swSync   <= 2'b00;
        end else begin
            r_lockSync <= {r_lockSync[0], locked};
            r_swSync   <= {r_swSync[0], swReset};
        end
    end

    assign w_lockedS = r_lockSync[1];
    assign w_swS     = r_swSync[1];

`ifdef ESM_RST_DEBOUNCE_EN
    localparam logic [19:0] c_DB_M1 = (DEBOUNCE_CYCLES == 0) ? 20'd0 : 20'(DEBOUNCE_CYCLES - 1);

    logic        r_swF;
    logic [19:0] r_dbCnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_swF   <= 1'b0;
            r_dbCnt <= '0;
        end else if (w_swS == r_swF) begin
            r_dbCnt <= '0;
        end else if (r_dbCnt == c_DB_M1) begin
            r_swF   <= w_swS;
            r_dbCnt <= '0;
        end else begin
            r_dbCnt <= r_dbCnt + 20'd1;
        end
    end

    assign w_swF = r_swF;
`else
    assign w_swF = w_swS;

    // DEBOUNCE_CYCLES has no role without the debounce filter
    if (DEBOUNCE_CYCLES < 0) begin : g_db_unused
    end
`endif

    always_comb begin
        w_next       = r_state;
        w_cntNext    = r_cnt;
        w_swHeldNext = 1'b0;
        w_lossInc    = 1'b0;

        if (r_state != S_WAITLOCK && !w_lockedS) begin
            w_next    = S_WAITLOCK;
            w_cntNext = '0;
            w_lossInc = 1'b1;
        end else if (r_state != S_WAITLOCK && w_swF) begin
            w_next       = S_STRETCH;
            w_cntNext    = '0;
            w_swHeldNext = 1'b1;
        end else begin
            case (r_state)
                S_WAITLOCK: begin
                    w_cntNext = '0;
                    if (w_lockedS) w_next = S_STRETCH;
                end
                S_STRETCH: begin
                    // The edge that first sees the request gone acts as a fresh
                    // STRETCH entry, mirroring the lock-to-STRETCH entry edge.
                    if (r_swHeld) begin
                        w_cntNext = '0;
                    end else if (r_cnt == c_STRETCH_M1) begin
                        w_next    = S_MEM;
                        w_cntNext = '0;
                    end else begin
                        w_cntNext = r_cnt + 20'd1;
                    end
                end
                S_MEM: begin
                    if (r_cnt == c_STAGE_M1) begin
                        w_next    = S_BUS;
                        w_cntNext = '0;
                    end else begin
                        w_cntNext = r_cnt + 20'd1;
                    end
                end
                S_BUS: begin
                    if (r_cnt == c_STAGE_M1) begin
                        w_next    = S_RUN;
                        w_cntNext = '0;
                    end else begin
                        w_cntNext = r_cnt + 20'd1;
                    end
                end
                S_RUN: begin
                    w_cntNext = '0;
                end
                default: begin
                    w_next    = S_WAITLOCK;
                    w_cntNext = '0;
                end
            endcase
        end

        w_rstMem = 1'b1;
        w_rstBus = 1'b1;
        w_rstCpu = 1'b1;
        w_ready  = 1'b0;
        case (w_next)
            S_MEM: w_rstMem = 1'b0;
            S_BUS: begin
                w_rstMem = 1'b0;
                w_rstBus = 1'b0;
            end
            S_RUN: begin
                w_rstMem = 1'b0;
                w_rstBus = 1'b0;
                w_rstCpu = 1'b0;
                w_ready  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= S_WAITLOCK;
            r_cnt     <= '0;
            r_swHeld  <= 1'b0;
            r_lossCnt <= 8'd0;
            r_rstMem  <= 1'b1;
            r_rstBus  <= 1'b1;
            r_rstCpu  <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cntNext;
            r_swHeld <= w_swHeldNext;
            if (w_lossInc && r_lossCnt != 8'hFF) r_lossCnt <= r_lossCnt + 8'd1;
            r_rstMem <= w_rstMem;
            r_rstBus <= w_rstBus;
            r_rstCpu <= w_rstCpu;
            r_ready  <= w_ready;
        end
    end

    assign rstMem  = r_rstMem;
    assign rstBus  = r_rstBus;
    assign rstCpu  = r_rstCpu;
    assign ready   = r_ready;
    assign state   = r_state;
    assign lossCnt = r_lossCnt;

endmodule
`default_nettype wire

// File: tb/tb_esm_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_esm_rst_seq
// Description : Scoreboard bench for esm_rst_seq (STRETCH=8, STAGE=4, DEBOUNCE=16).
// Revision    : 1.0  initial release
// ============================================================================
module tb_esm_rst_seq;

    logic       clk;
    logic       rstN;
    logic       locked;
    logic       swReset;
    logic       rstMem, rstBus, rstCpu, ready;
    logic [2:0] state;
    logic [7:0] lossCnt;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    int          q_cyc[$];
    logic [14:0] q_val[$];
    string       q_name[$];

    esm_rst_seq #(
        .STRETCH_CYCLES (8),
        .STAGE_CYCLES   (4),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk    (clk),
        .rstN   (rstN),
        .locked (locked),
        .swReset(swReset),
        .rstMem (rstMem),
        .rstBus (rstBus),
        .rstCpu (rstCpu),
        .ready  (ready),
        .state  (state),
        .lossCnt(lossCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // {rstMem, rstBus, rstCpu, ready} expected for each state
    function automatic logic [3:0] outs_of(input logic [2:0] st);
        case (st)
            3'd2:    return 4'b0110;
            3'd3:    return 4'b0010;
            3'd4:    return 4'b0001;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic expect_at(input int c, input string nm, input logic [2:0] st, input logic [7:0] loss);
        q_cyc.push_back(c);
        q_val.push_back({st, outs_of(st), loss});
        q_name.push_back(nm);
    endtask

    task automatic wait_to(input int c);
        while (edge_cnt < c) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            while (q_cyc.size() > 0 && q_cyc[0] <= edge_cnt) begin
                int          c;
                logic [14:0] e;
                logic [14:0] a;
                string       n;
                c = q_cyc.pop_front();
                e = q_val.pop_front();
                n = q_name.pop_front();
                a = {state, rstMem, rstBus, rstCpu, ready, lossCnt};
                checks++;
                if (a !== e || c != edge_cnt) begin
                    failures++;
                    $display("FAIL %s edge=%0d due=%0d: got st=%0d mbcr=%b loss=%0d, want st=%0d mbcr=%b loss=%0d",
                             n, edge_cnt, c, a[14:12], a[11:8], a[7:0], e[14:12], e[11:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int n;
        int loss;
        rstN    = 1'b0;
        locked  = 1'b1;
        swReset = 1'b0;
        repeat (3) @(negedge clk);
        expect_at(edge_cnt, "reset", 3'd0, 8'd0);

        // Reset release with lock already present
        b = edge_cnt;
        rstN = 1'b1;
        expect_at(b + 2,  "t1_sync",     3'd0, 8'd0);
        expect_at(b + 3,  "t1_stretch",  3'd1, 8'd0);
        expect_at(b + 10, "t1_stretch_e",3'd1, 8'd0);
        expect_at(b + 11, "t1_mem",      3'd2, 8'd0);
        expect_at(b + 14, "t1_mem_e",    3'd2, 8'd0);
        expect_at(b + 15, "t1_bus",      3'd3, 8'd0);
        expect_at(b + 18, "t1_bus_e",    3'd3, 8'd0);
        expect_at(b + 19, "t1_run",      3'd4, 8'd0);
        wait_to(b + 22);

        // Lock loss in RUN for 5 cycles, then full re-sequence
        b = edge_cnt;
        locked = 1'b0;
        expect_at(b + 2,  "t2_pre",      3'd4, 8'd0);
        expect_at(b + 3,  "t2_loss",     3'd0, 8'd1);
        expect_at(b + 5,  "t2_wait",     3'd0, 8'd1);
        wait_to(b + 5);
        locked = 1'b1;
        expect_at(b + 7,  "t2_relock0",  3'd0, 8'd1);
        expect_at(b + 8,  "t2_stretch",  3'd1, 8'd1);
        expect_at(b + 15, "t2_stretch_e",3'd1, 8'd1);
        expect_at(b + 16, "t2_mem",      3'd2, 8'd1);
        expect_at(b + 20, "t2_bus",      3'd3, 8'd1);
        expect_at(b + 23, "t2_bus_e",    3'd3, 8'd1);
        expect_at(b + 24, "t2_run",      3'd4, 8'd1);
        wait_to(b + 27);

        // swReset held 10 cycles in RUN; swF falls after edge b+12
        b = edge_cnt;
        swReset = 1'b1;
        expect_at(b + 2,  "t3_pre",      3'd4, 8'd1);
        expect_at(b + 3,  "t3_stretch",  3'd1, 8'd1);
        expect_at(b + 8,  "t3_hold",     3'd1, 8'd1);
        wait_to(b + 10);
        swReset = 1'b0;
        expect_at(b + 12, "t3_hold_e",   3'd1, 8'd1);
        expect_at(b + 20, "t3_stretch_e",3'd1, 8'd1);
        expect_at(b + 21, "t3_mem",      3'd2, 8'd1);
        expect_at(b + 25, "t3_bus",      3'd3, 8'd1);
        expect_at(b + 28, "t3_bus_e",    3'd3, 8'd1);
        expect_at(b + 29, "t3_run",      3'd4, 8'd1);
        wait_to(b + 32);

        // Simultaneous lock loss and swReset: lock loss wins, one increment
        b = edge_cnt;
        locked  = 1'b0;
        swReset = 1'b1;
        expect_at(b + 2,  "t4_pre",      3'd4, 8'd1);
        expect_at(b + 3,  "t4_loss",     3'd0, 8'd2);
        expect_at(b + 4,  "t4_once",     3'd0, 8'd2);
        wait_to(b + 5);
        locked  = 1'b1;
        swReset = 1'b0;
        expect_at(b + 7,  "t4_wait",     3'd0, 8'd2);
        expect_at(b + 8,  "t4_stretch",  3'd1, 8'd2);
        wait_to(b + 8);

        // 300 lock-loss events; count saturates at 255
        loss = 2;
        for (int i = 0; i < 300; i++) begin
            n = edge_cnt;
            locked = 1'b0;
            loss = (loss < 255) ? loss + 1 : 255;
            expect_at(n + 3, "t5_loss", 3'd0, 8'(loss));
            wait_to(n + 3);
            locked = 1'b1;
            wait_to(n + 6);
        end
        b = edge_cnt;
        expect_at(b + 1,  "t5_sat",      3'd1, 8'd255);
        expect_at(b + 16, "t5_run",      3'd4, 8'd255);
        wait_to(b + 18);

        // 10-cycle swReset pulse
        b = edge_cnt;
        swReset = 1'b1;
`ifdef ESM_RST_DEBOUNCE_EN
        expect_at(b + 3,  "t6_glitch_a", 3'd4, 8'd255);
        wait_to(b + 10);
        swReset = 1'b0;
        expect_at(b + 12, "t6_glitch_b", 3'd4, 8'd255);
        expect_at(b + 30, "t6_glitch_c", 3'd4, 8'd255);
        wait_to(b + 32);
        b = edge_cnt;
        swReset = 1'b1;
        expect_at(b + 18, "t6_long_pre", 3'd4, 8'd255);
        expect_at(b + 19, "t6_long",     3'd1, 8'd255);
        wait_to(b + 20);
        swReset = 1'b0;
        expect_at(b + 30, "t6_long_hold",3'd1, 8'd255);
        wait_to(b + 32);
`else
        expect_at(b + 2,  "t6_pre",      3'd4, 8'd255);
        expect_at(b + 3,  "t6_stretch",  3'd1, 8'd255);
        wait_to(b + 10);
        swReset = 1'b0;
        expect_at(b + 12, "t6_hold",     3'd1, 8'd255);
        expect_at(b + 28, "t6_bus_e",    3'd3, 8'd255);
        expect_at(b + 29, "t6_run",      3'd4, 8'd255);
        wait_to(b + 30);
`endif

        // Asynchronous reset mid-operation
        b = edge_cnt;
        rstN = 1'b0;
        expect_at(b,     "t7_async",     3'd0, 8'd0);
        expect_at(b + 2, "t7_held",      3'd0, 8'd0);
        wait_to(b + 3);
        rstN = 1'b1;
        expect_at(b + 5, "t7_sync",      3'd0, 8'd0);
        expect_at(b + 6, "t7_stretch",   3'd1, 8'd0);
        wait_to(b + 8);

        for (int i = 0; i < 50 && q_cyc.size() > 0; i++) @(negedge clk);
        if (q_cyc.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", q_cyc.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
